// File: rtl/uart_pkg.sv
// UART receiver shared definitions.
// Parity/stop codes, FSM states and config field layout.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_PUSH
  } state_t;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam int CFG_PRE_LSB  = 0;
  localparam int CFG_PAR_LSB  = 16;
  localparam int CFG_BSZ_LSB  = 19;
  localparam int CFG_STOP_BIT = 23;
  localparam int CFG_EN_BIT   = 25;

  typedef struct packed {
    logic        rx_en;
    logic        stop;
    logic [3:0]  bsz;
    logic [2:0]  par;
    logic [15:0] pre;
  } cfg_t;

  function automatic cfg_t cfg_parse(
    input logic [26:0] d
  );
    cfg_t c;
    c.rx_en = d[CFG_EN_BIT];
    c.stop  = d[CFG_STOP_BIT];
    c.bsz   = d[CFG_BSZ_LSB +: 4];
    c.par   = d[CFG_PAR_LSB +: 3];
    c.pre   = d[CFG_PRE_LSB +: 16];
    return c;
  endfunction

  function automatic logic [15:0] eff_pre(
    input logic [15:0] p
  );
    return (p < 16'd2) ? 16'd2 : p;
  endfunction

  // 4-bit field: 0 encodes 16, values below 5 clamp to 5
  function automatic logic [4:0] eff_bsz(
    input logic [3:0] b
  );
    if (b == 4'd0) return 5'd16;
    if (b < 4'd5) return 5'd5;
    return {1'b0, b};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Config and receive-data AXI-Stream bundle
// of the UART receiver.
interface uart_rx_if;
  logic [26:0] s_axis_config_tdata;
  logic        s_axis_config_tvalid;
  logic        s_axis_config_tready;
  logic [15:0] m_axis_tdata;
  logic [2:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport slave (
    input  s_axis_config_tdata,
    input  s_axis_config_tvalid,
    output s_axis_config_tready,
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_config_tdata,
    output s_axis_config_tvalid,
    input  s_axis_config_tready,
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/uart_fifo.sv
// Show-ahead FIFO for received words;
// output reads zero while empty.
module uart_fifo #(
  parameter int DATA_WIDTH = 19,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [AW:0]           count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic wr_ok;
  logic rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge aclk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampling bit timer FSM
// feeding a flagged-word FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_PRESCALER = 12,
  parameter int PARITY         = 0,
  parameter int BYTE_SIZE      = 8,
  parameter int STOP_BITS      = 0,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  uart_rx_if.slave    bus,
  output logic [31:0] rx_data_count,
  input  logic        rxd,
  output logic        rtsn
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam cfg_t CFG_RST = '{
    rx_en: 1'b1,
    stop:  1'(STOP_BITS),
    bsz:   4'(BYTE_SIZE),
    par:   3'(PARITY),
    pre:   16'(BAUD_PRESCALER)
  };

  state_t state;
  state_t nxt;
  cfg_t cfg;
  cfg_t fcfg;

  logic rx_s1;
  logic rx_s2;
  logic rx_q;
  logic fall;

  logic [15:0] tmr;
  logic [4:0]  cnt;
  logic [15:0] word;
  logic expire;
  logic start;
  logic push;
  logic pe;
  logic fe;
  logic ovr;
  logic has_par;
  logic par_exp;
  logic last_bit;
  logic last_stop;

  logic          f_full;
  logic          f_empty;
  logic [18:0]   f_rd;
  logic [AW:0]   f_cnt;
  logic          unused_fcfg;

  assign unused_fcfg = fcfg.rx_en;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  assign fall   = rx_q && !rx_s2;
  assign expire = (tmr == 16'd1);

  assign bus.s_axis_config_tready = (state == S_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg <= CFG_RST;
    end else if (bus.s_axis_config_tvalid &&
                 bus.s_axis_config_tready) begin
      cfg <= cfg_parse(bus.s_axis_config_tdata);
    end
  end

  assign has_par   = (fcfg.par >= PAR_EVEN) &&
                     (fcfg.par <= PAR_SPACE);
  assign last_bit  = (cnt == eff_bsz(fcfg.bsz) - 5'd1);
  assign last_stop = (cnt == {4'd0, fcfg.stop});

  always_comb begin
    par_exp = 1'b0;
    unique case (1'b1)
      fcfg.par == PAR_EVEN: par_exp = ^word;
      fcfg.par == PAR_ODD:  par_exp = ~^word;
      fcfg.par == PAR_MARK: par_exp = 1'b1;
      default:              par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt   = state;
    start = 1'b0;
    push  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cfg.rx_en && fall) begin
          nxt   = S_START;
          start = 1'b1;
        end
      end
      S_START: begin
        if (expire) nxt = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (expire && last_bit)
          nxt = has_par ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (expire) nxt = S_STOP;
      end
      S_STOP: begin
        if (expire && last_stop) nxt = S_PUSH;
      end
      S_PUSH: begin
        push = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmr  <= '0;
      cnt  <= '0;
      word <= '0;
      fcfg <= CFG_RST;
      pe   <= 1'b0;
      fe   <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (start) begin
        tmr  <= eff_pre(cfg.pre) >> 1;
        fcfg <= cfg;
        cnt  <= '0;
        word <= '0;
      end else if (state != S_IDLE &&
                   state != S_PUSH) begin
        if (expire) begin
          tmr <= eff_pre(fcfg.pre);
          cnt <= (nxt == state) ? cnt + 5'd1 : 5'd0;
          if (state == S_DATA)
            word[cnt[3:0]] <= rx_s2;
          if (state == S_PAR && rx_s2 != par_exp)
            pe <= 1'b1;
          if (state == S_STOP && !rx_s2)
            fe <= 1'b1;
        end else begin
          tmr <= tmr - 16'd1;
        end
      end
      // a dropped word arms overrun for the next stored one
      if (push) begin
        pe  <= 1'b0;
        fe  <= 1'b0;
        ovr <= f_full;
      end
    end
  end

  uart_fifo #(
    .DATA_WIDTH (19),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (push),
    .wr_data ({ovr, fe, pe, word}),
    .full    (f_full),
    .rd_en   (bus.m_axis_tready),
    .rd_data (f_rd),
    .empty   (f_empty),
    .count   (f_cnt)
  );

  assign bus.m_axis_tvalid = !f_empty;
  assign bus.m_axis_tdata  = f_rd[15:0];
  assign bus.m_axis_tuser  = f_rd[18:16];
  assign rx_data_count     = 32'(f_cnt);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rtsn <= 1'b1;
    end else begin
      rtsn <= (rx_data_count >= 32'(FIFO_DEPTH - 2)) ||
              !cfg.rx_en;
    end
  end

endmodule
